flash_page_writer: RTL and testbench



---
 rtl/flash_page_writer_pkg.sv | 44 ++++
 rtl/flash_page_writer.sv | 235 +++++++++++++++++++++++
 tb/tb_flash_page_writer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_page_writer_pkg.sv
// flash_page_writer_pkg
// Shared constants and types for the flash page programming sequencer:
// flash opcodes, page geometry, controller data_send width, and the
// sequencer's main-state / command-phase encodings.
package flash_page_writer_pkg;

    localparam int PAGE_BYTES  = 256;
    localparam int BUF_W       = PAGE_BYTES * 8;
    localparam int DATA_SEND_W = (3 + PAGE_BYTES) * 8;

    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_SE   = 8'hD8;
    localparam logic [7:0] CMD_PP   = 8'h02;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_CHK    = 4'd1,
        ST_WREN_E = 4'd2,
        ST_SE     = 4'd3,
        ST_FILL   = 4'd4,
        ST_WREN_P = 4'd5,
        ST_PP     = 4'd6,
        ST_NEXT   = 4'd7,
        ST_FINISH = 4'd8
    } state_t;

    // Handshake phase used while a main state is issuing a controller command.
    typedef enum logic [1:0] {
        PH_ISSUE = 2'd0,
        PH_ACK   = 2'd1,
        PH_CMPL  = 2'd2
    } phase_t;

    // True for the main states that run the ISSUE/ACK/CMPL handshake.
    function automatic logic is_cmd_state(input state_t s);
        logic r;
        case (s)
            ST_WREN_E, ST_SE, ST_WREN_P, ST_PP: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/flash_page_writer.sv
// flash_page_writer
// Turns a host byte stream into per-page flash programming commands for
// qspi_mem_controller: WREN+SE at the first page of a job and at each 64 KiB
// sector boundary, then WREN+PP per 256-byte page.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start/start_addr/num_pages/quad   job request (taken only in IDLE)
//   in_data/in_valid/in_ready         byte stream, accepted on valid&ready
//   busy/done/error                   job status (error sticky until next start)
//   ctrl_trigger/quad/cmd/data_send   command to the controller
//   ctrl_busy/ctrl_error              controller status
module flash_page_writer
    import flash_page_writer_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [23:0]            start_addr,
    input  logic [15:0]            num_pages,
    input  logic                   quad,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   ctrl_trigger,
    output logic                   ctrl_quad,
    output logic [7:0]             ctrl_cmd,
    output logic [DATA_SEND_W-1:0] ctrl_data_send,
    input  logic                   ctrl_busy,
    input  logic                   ctrl_error
);

    state_t                 state_r, state_s;
    phase_t                 phase_r, phase_s;
    logic [23:0]            addr_r;
    logic [15:0]            pages_left_r;
    logic [BUF_W-1:0]       buf_r;
    logic [7:0]             cnt_r;
    logic                   first_r;
    logic                   quad_r;
    logic                   error_r;
    logic                   busy_r, busy_s;
    logic                   done_r, done_s;
    logic                   trigger_r, trigger_s;
    logic [7:0]             cmd_r, cmd_s;
    logic [DATA_SEND_W-1:0] data_r, data_s;
    logic                   start_acc_s;
    logic                   cmd_done_s;
    logic                   unused_s;

    // Low address byte is always forced to zero, so those bits are never read.
    assign unused_s = ^start_addr[7:0];

    assign start_acc_s = start && (state_r == ST_IDLE);
    assign cmd_done_s  = is_cmd_state(state_r) && (phase_r == PH_CMPL) && !ctrl_busy;

    assign in_ready       = (state_r == ST_FILL);
    assign busy           = busy_r;
    assign done           = done_r;
    assign error          = error_r;
    assign ctrl_trigger   = trigger_r;
    assign ctrl_quad      = quad_r;
    assign ctrl_cmd       = cmd_r;
    assign ctrl_data_send = data_r;

    // State register: main state plus command handshake phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            phase_r <= PH_ISSUE;
        end else begin
            state_r <= state_s;
            phase_r <= phase_s;
        end
    end

    // Next-state logic for the job sequence and the shared command handshake.
    always_comb begin
        state_s = state_r;
        phase_s = phase_r;
        case (state_r)
            ST_IDLE: begin
                if (start_acc_s) begin
                    state_s = (num_pages == 16'd0) ? ST_FINISH : ST_CHK;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (first_r || (addr_r[15:0] == 16'h0000)) begin
                    state_s = ST_WREN_E;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_WREN_E, ST_SE, ST_WREN_P, ST_PP: begin
                case (phase_r)
                    PH_ISSUE: begin
                        if (!ctrl_busy) begin
                            phase_s = PH_ACK;
                        end else begin
                            phase_s = PH_ISSUE;
                        end
                    end
                    PH_ACK: begin
                        if (ctrl_busy) begin
                            phase_s = PH_CMPL;
                        end else begin
                            phase_s = PH_ACK;
                        end
                    end
                    PH_CMPL: begin
                        if (!ctrl_busy) begin
                            phase_s = PH_ISSUE;
                            // Controller never flags an error on WREN.
                            case (state_r)
                                ST_WREN_E: state_s = ST_SE;
                                ST_SE:     state_s = ctrl_error ? ST_FINISH : ST_FILL;
                                ST_WREN_P: state_s = ST_PP;
                                ST_PP:     state_s = ctrl_error ? ST_FINISH : ST_NEXT;
                                default:   state_s = ST_IDLE;
                            endcase
                        end else begin
                            phase_s = PH_CMPL;
                        end
                    end
                    default: phase_s = PH_ISSUE;
                endcase
            end
            ST_FILL: begin
                if (in_valid && (cnt_r == 8'hFF)) begin
                    state_s = ST_WREN_P;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_NEXT: begin
                if (pages_left_r == 16'd1) begin
                    state_s = ST_FINISH;
                end else begin
                    state_s = ST_CHK;
                end
            end
            ST_FINISH: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, keyed on the
    // upcoming state so cmd/data_send are already stable when trigger fires.
    always_comb begin
        busy_s    = !((state_s == ST_IDLE) || (state_s == ST_FINISH));
        done_s    = (state_s == ST_FINISH);
        trigger_s = is_cmd_state(state_r) && (phase_r == PH_ISSUE) && !ctrl_busy;
        case (state_s)
            ST_WREN_E, ST_WREN_P: begin
                cmd_s  = CMD_WREN;
                data_s = {DATA_SEND_W{1'b0}};
            end
            ST_SE: begin
                cmd_s  = CMD_SE;
                data_s = {{(DATA_SEND_W-24){1'b0}}, addr_r};
            end
            ST_PP: begin
                cmd_s  = CMD_PP;
                data_s = {addr_r, buf_r};
            end
            default: begin
                cmd_s  = 8'h00;
                data_s = {DATA_SEND_W{1'b0}};
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            trigger_r <= 1'b0;
            cmd_r     <= 8'h00;
            data_r    <= {DATA_SEND_W{1'b0}};
        end else begin
            busy_r    <= busy_s;
            done_r    <= done_s;
            trigger_r <= trigger_s;
            cmd_r     <= cmd_s;
            data_r    <= data_s;
        end
    end

    // Job datapath: address/page bookkeeping, page buffer, sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r       <= 24'h000000;
            pages_left_r <= 16'd0;
            buf_r        <= {BUF_W{1'b0}};
            cnt_r        <= 8'd0;
            first_r      <= 1'b0;
            quad_r       <= 1'b0;
            error_r      <= 1'b0;
        end else if (start_acc_s) begin
            addr_r       <= {start_addr[23:8], 8'h00};
            pages_left_r <= num_pages;
            quad_r       <= quad;
            error_r      <= 1'b0;
            first_r      <= 1'b1;
            cnt_r        <= 8'd0;
        end else begin
            case (state_r)
                ST_CHK: first_r <= 1'b0;
                ST_FILL: begin
                    if (in_valid) begin
                        // Oldest byte ends up in the top byte of the page.
                        buf_r <= {buf_r[BUF_W-9:0], in_data};
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_SE, ST_PP: begin
                    if (cmd_done_s && ctrl_error) begin
                        error_r <= 1'b1;
                    end
                end
                ST_NEXT: begin
                    addr_r       <= addr_r + 24'h000100;
                    pages_left_r <= pages_left_r - 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_page_writer.sv
// tb_flash_page_writer
// Self-checking bench: a table of jobs plus random jobs is run against a
// behavioural controller model; the expected command list for each job is
// derived independently from the page/sector rules.
module tb_flash_page_writer;
    import flash_page_writer_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic [23:0]            start_addr;
    logic [15:0]            num_pages;
    logic                   quad;
    logic [7:0]             in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   busy;
    logic                   done;
    logic                   error;
    logic                   ctrl_trigger;
    logic                   ctrl_quad;
    logic [7:0]             ctrl_cmd;
    logic [DATA_SEND_W-1:0] ctrl_data_send;
    logic                   ctrl_busy;
    logic                   ctrl_error;

    always #5 clk = ~clk;

    flash_page_writer dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .num_pages(num_pages), .quad(quad), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .busy(busy), .done(done), .error(error),
        .ctrl_trigger(ctrl_trigger), .ctrl_quad(ctrl_quad), .ctrl_cmd(ctrl_cmd),
        .ctrl_data_send(ctrl_data_send), .ctrl_busy(ctrl_busy), .ctrl_error(ctrl_error)
    );

    typedef struct {
        logic [23:0] addr;
        int          np;
        int          err_idx;   // command index at which controller reports error, -1 none
        bit          quad;
        bit          counting;  // bytes are 0,1,2,... instead of random
        bit          gaps;      // random in_valid gaps
        int          exp_cmds;  // hand-derived command count, -1 = not tabulated
        bit          exp_err;
    } vec_t;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0]             tx_q[$];
    logic [7:0]             all_bytes[$];
    logic [7:0]             cmd_q[$];
    logic [DATA_SEND_W-1:0] dat_q[$];
    logic [7:0]             exp_cmd_q[$];
    logic [DATA_SEND_W-1:0] exp_dat_q[$];
    bit                     exp_err;

    int done_cnt, trig_busy_viol, consec_viol, quad_bad, busy_at_done, bytes_acc;
    bit prev_trig, ready_seen, gaps_cur, job_quad, ctl_pend;
    int ctl_ph, ctl_cnt, cmd_seen, err_idx_cur;

    task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // One clock cycle: monitor DUT, advance controller model, drive stream.
    task automatic step();
        bit acc, rst_now;
        acc     = in_valid && in_ready && !reset;
        rst_now = reset;
        @(negedge clk);
        if (acc) begin
            void'(tx_q.pop_front());
            bytes_acc++;
        end
        if (ctrl_trigger) begin
            cmd_q.push_back(ctrl_cmd);
            dat_q.push_back(ctrl_data_send);
            if (ctrl_busy) trig_busy_viol++;
            if (prev_trig) consec_viol++;
            if (ctrl_quad != job_quad) quad_bad++;
        end
        prev_trig = ctrl_trigger;
        if (done) begin
            done_cnt++;
            if (busy) busy_at_done++;
        end
        if (in_ready) ready_seen = 1'b1;
        if (rst_now) begin
            ctrl_busy = 1'b1; ctrl_error = 1'b0; ctl_ph = 2; ctl_cnt = 3; ctl_pend = 1'b0;
        end else begin
            case (ctl_ph)
                0: if (ctrl_trigger) begin
                    ctrl_error = 1'b0;
                    ctl_pend   = (cmd_seen == err_idx_cur);
                    cmd_seen++;
                    ctl_cnt    = $urandom_range(0, 2);
                    ctl_ph     = 1;
                end
                1: if (ctl_cnt == 0) begin
                    ctrl_busy = 1'b1; ctl_cnt = $urandom_range(1, 4); ctl_ph = 2;
                end else ctl_cnt--;
                default: if (ctl_cnt == 0) begin
                    ctrl_busy = 1'b0; ctrl_error = ctl_pend; ctl_ph = 0;
                end else ctl_cnt--;
            endcase
        end
        if (tx_q.size() > 0 && (!gaps_cur || $urandom_range(0, 3) != 0)) begin
            in_valid = 1'b1; in_data = tx_q[0];
        end else begin
            in_valid = 1'b0; in_data = 8'h00;
        end
    endtask

    // Reference: command list from the page/sector rules.
    task automatic build_model(input logic [23:0] sa, input int np, input int err);
        logic [23:0]            a;
        logic [BUF_W-1:0]       pg;
        logic [DATA_SEND_W-1:0] d;
        int idx;
        bit stop;
        a = {sa[23:8], 8'h00}; idx = 0; stop = 1'b0;
        exp_cmd_q.delete(); exp_dat_q.delete();
        for (int p = 0; p < np && !stop; p++) begin
            if (p == 0 || a[15:0] == 16'h0000) begin
                exp_cmd_q.push_back(8'h06); exp_dat_q.push_back('0); idx++;
                d = '0; d[23:0] = a;
                exp_cmd_q.push_back(8'hD8); exp_dat_q.push_back(d);
                if (idx == err) stop = 1'b1;
                idx++;
            end
            if (!stop) begin
                exp_cmd_q.push_back(8'h06); exp_dat_q.push_back('0); idx++;
                for (int k = 0; k < 256; k++) pg[BUF_W-1-8*k -: 8] = all_bytes[p*256+k];
                exp_cmd_q.push_back(8'h02); exp_dat_q.push_back({a, pg});
                if (idx == err) stop = 1'b1;
                idx++;
                a = a + 24'h000100;
            end
        end
        exp_err = stop;
    endtask

    task automatic setup_job(input vec_t v);
        logic [7:0] b;
        cmd_q.delete(); dat_q.delete(); tx_q.delete(); all_bytes.delete();
        for (int i = 0; i < v.np * 256; i++) begin
            b = v.counting ? 8'(i) : 8'($urandom);
            tx_q.push_back(b); all_bytes.push_back(b);
        end
        done_cnt = 0; trig_busy_viol = 0; consec_viol = 0; quad_bad = 0; busy_at_done = 0;
        bytes_acc = 0; ready_seen = 1'b0; cmd_seen = 0;
        err_idx_cur = v.err_idx; gaps_cur = v.gaps; job_quad = v.quad;
        build_model(v.addr, v.np, v.err_idx);
        start_addr = v.addr; num_pages = 16'(v.np); quad = v.quad; start = 1'b1;
        step();
        start = 1'b0; quad = ~v.quad;
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int cyc, n;
        setup_job(v);
        if (v.np > 0) check({tag, " busy_rise"}, busy == 1'b1, 64'(busy), 64'd1);
        cyc = 1;
        while (done_cnt == 0 && cyc < v.np * 1200 + 400) begin
            step(); cyc++;
        end
        check({tag, " done_seen"}, done_cnt == 1, 64'(done_cnt), 64'd1);
        if (v.np == 0) check({tag, " zero_len_latency"}, cyc <= 2, 64'(cyc), 64'd2);
        step(); step();
        check({tag, " done_one_pulse"}, done_cnt == 1, 64'(done_cnt), 64'd1);
        check({tag, " busy_low_at_done"}, busy_at_done == 0, 64'(busy_at_done), 64'd0);
        check({tag, " error"}, error == exp_err, 64'(error), 64'(exp_err));
        if (v.exp_cmds >= 0) begin
            check({tag, " table_cmds"}, cmd_q.size() == v.exp_cmds, 64'(cmd_q.size()), 64'(v.exp_cmds));
            check({tag, " table_err"}, error == v.exp_err, 64'(error), 64'(v.exp_err));
        end
        check({tag, " model_cmds"}, cmd_q.size() == exp_cmd_q.size(), 64'(cmd_q.size()), 64'(exp_cmd_q.size()));
        n = (cmd_q.size() < exp_cmd_q.size()) ? cmd_q.size() : exp_cmd_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s cmd%0d", tag, i), cmd_q[i] == exp_cmd_q[i], 64'(cmd_q[i]), 64'(exp_cmd_q[i]));
            check($sformatf("%s data%0d", tag, i), dat_q[i] == exp_dat_q[i],
                  {8'h00, dat_q[i][2071:2048], dat_q[i][31:0]},
                  {8'h00, exp_dat_q[i][2071:2048], exp_dat_q[i][31:0]});
        end
        check({tag, " trig_while_busy"}, trig_busy_viol == 0, 64'(trig_busy_viol), 64'd0);
        check({tag, " trig_consecutive"}, consec_viol == 0, 64'(consec_viol), 64'd0);
        check({tag, " quad_latched"}, quad_bad == 0, 64'(quad_bad), 64'd0);
        if (v.err_idx == 1) check({tag, " no_in_ready"}, ready_seen == 1'b0, 64'(ready_seen), 64'd0);
    endtask

    vec_t vecs[8];
    vec_t rv;

    initial begin
        int cyc;
        reset = 1'b1; start = 1'b0; start_addr = '0; num_pages = '0; quad = 1'b0;
        in_data = 8'h00; in_valid = 1'b0; ctrl_busy = 1'b1; ctrl_error = 1'b0;
        ctl_ph = 2; ctl_cnt = 3; ctl_pend = 1'b0; prev_trig = 1'b0; gaps_cur = 1'b0;
        job_quad = 1'b0; err_idx_cur = -1; cmd_seen = 0; bytes_acc = 0;
        //          addr         np err quad cnt gaps cmds err
        vecs[0] = '{24'h010000, 1, -1, 1'b0, 1'b1, 1'b0, 4, 1'b0};
        vecs[1] = '{24'h00FF37, 2, -1, 1'b1, 1'b0, 1'b1, 8, 1'b0};
        vecs[2] = '{24'h020000, 3, -1, 1'b0, 1'b0, 1'b0, 8, 1'b0};
        vecs[3] = '{24'h030000, 2,  1, 1'b0, 1'b0, 1'b0, 2, 1'b1};
        vecs[4] = '{24'h000000, 0, -1, 1'b1, 1'b0, 1'b0, 0, 1'b0};
        vecs[5] = '{24'hFFFF00, 2, -1, 1'b0, 1'b0, 1'b1, 8, 1'b0};
        vecs[6] = '{24'h040000, 2,  3, 1'b1, 1'b0, 1'b1, 4, 1'b1};
        vecs[7] = '{24'h05FF00, 1, -1, 1'b1, 1'b1, 1'b1, 4, 1'b0};

        for (int i = 0; i < 3; i++) step();
        check("reset busy", busy == 1'b0, 64'(busy), 64'd0);
        check("reset outputs", {done, error, in_ready, ctrl_trigger, ctrl_quad, ctrl_cmd} == 13'd0,
              64'({done, error, in_ready, ctrl_trigger, ctrl_quad, ctrl_cmd}), 64'd0);
        check("reset data_send", ctrl_data_send == '0, 64'(ctrl_data_send[63:0]), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_job(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of FILL, then a normal job.
        rv = '{24'h060000, 1, -1, 1'b1, 1'b0, 1'b1, 4, 1'b0};
        setup_job(rv);
        cyc = 0;
        while (bytes_acc < 100 && cyc < 2000) begin
            step(); cyc++;
        end
        check("midfill reached", bytes_acc == 100, 64'(bytes_acc), 64'd100);
        reset = 1'b1;
        step();
        check("midfill reset busy", busy == 1'b0, 64'(busy), 64'd0);
        check("midfill reset outputs", {done, error, in_ready, ctrl_trigger, ctrl_quad, ctrl_cmd} == 13'd0,
              64'({done, error, in_ready, ctrl_trigger, ctrl_quad, ctrl_cmd}), 64'd0);
        check("midfill reset data_send", ctrl_data_send == '0, 64'(ctrl_data_send[2071:2008]), 64'd0);
        reset = 1'b0;
        trig_busy_viol = 0;
        for (int i = 0; i < 4; i++) step();
        check("midfill no trigger after reset", cmd_seen == 2 && trig_busy_viol == 0, 64'(cmd_seen), 64'd2);
        run_job(rv, "after_reset");

        // Random jobs, some near sector boundaries, some with injected errors.
        for (int j = 0; j < 5; j++) begin
            rv.addr     = ($urandom_range(0, 1) == 1) ? 24'($urandom) : {8'($urandom), 16'hFE00};
            rv.np       = $urandom_range(1, 3);
            rv.err_idx  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : -1;
            rv.quad     = 1'($urandom);
            rv.counting = 1'b0;
            rv.gaps     = 1'($urandom);
            rv.exp_cmds = -1;
            rv.exp_err  = 1'b0;
            run_job(rv, $sformatf("rnd%0d", j));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
